// File: rtl/ifu_fetch.sv
// ifu_fetch -- multi-cycle instruction fetch unit.
//
// Each instruction goes through three steps:
//   REQ  : send a fetch request for pc.
//   WAIT : wait for the instruction word to come back.
//   HOLD : present the instruction to the decoder until it is retired.
// The unit then moves to the next pc. It stops permanently (HALT) on an
// ebreak, or on a jump or branch target that is not word aligned.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   pc_src          next-pc select: 0 = snpc, 1 = alu_result (bit 0 cleared)
//   alu_result      jump/branch target from the execute datapath
//   inst_done       the consumer has finished the held instruction
//   imem_req_*      request channel (valid/ready, 32-bit address)
//   imem_rsp_*      response channel (valid/ready, 32-bit data)
//   inst, inst_valid, pc, snpc
//                   the held instruction, its address, and that address + 4
//   halted, fault   fetch has stopped; fault = the stop was a misaligned target
//   instret         count of retired instructions (wraps at 2^32)
module ifu_fetch #(
    parameter logic [31:0] RESET_PC    = 32'h8000_0000,
    parameter logic [31:0] EBREAK_INST = 32'h0010_0073
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_src,
    input  logic [31:0] alu_result,
    input  logic        inst_done,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    output logic        imem_rsp_ready,
    input  logic [31:0] imem_rsp_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] snpc,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instret
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state, state_next;
    logic [31:0] next_pc;
    logic        is_ebreak;

    assign snpc      = pc + 32'd4;
    assign next_pc   = pc_src ? (alu_result & ~32'h1) : snpc;
    assign is_ebreak = (inst == EBREAK_INST);

    // State register.
    // NOTE: all sequential state uses non-blocking assignments so that every
    // register samples values from before the clock edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case statement, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            S_REQ:  if (imem_req_ready) state_next = S_WAIT;
            S_WAIT: if (imem_rsp_valid) state_next = S_HOLD;
            S_HOLD: begin
                if (inst_done) begin
                    if (is_ebreak || next_pc[1]) state_next = S_HALT;
                    else                         state_next = S_REQ;
                end
            end
            default: state_next = S_HALT;
        endcase
    end

    // Outputs are decoded from the state only. The request valid is also
    // masked by reset: the state register sits in REQ during reset, but no
    // request may be issued until reset is released.
    always_comb begin
        imem_req_valid = (state == S_REQ) && !rst;
        imem_rsp_ready = (state == S_WAIT);
        inst_valid     = (state == S_HOLD);
        halted         = (state == S_HALT);
        imem_addr      = pc;
    end

    // Datapath registers. They only change in WAIT (capture the word) and in
    // HOLD (retire), so HALT holds everything. A response that arrives outside
    // WAIT is ignored, and so is inst_done outside HOLD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc      <= RESET_PC;
            inst    <= 32'h0;
            fault   <= 1'b0;
            instret <= 32'h0;
        end else begin
            case (state)
                S_WAIT: begin
                    if (imem_rsp_valid) inst <= imem_rsp_data;
                end
                S_HOLD: begin
                    if (inst_done) begin
                        instret <= instret + 32'd1;
                        // An ebreak halts at its own pc; anything else moves
                        // pc even if the new target is misaligned, so the
                        // faulting target stays visible.
                        if (!is_ebreak) begin
                            pc <= next_pc;
                            if (next_pc[1]) fault <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifu_fetch.sv
// Testbench for ifu_fetch.
//
// The stimulus tasks push the expected request addresses and the expected
// held instructions into queues. A monitor that runs on the falling clock
// edge pops an entry and compares it whenever the DUT completes a request
// handshake or starts presenting an instruction. Inputs change 2 time units
// after the rising edge.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h8000_0000;
    localparam logic [31:0] EBREAK   = 32'h0010_0073;

    logic        clk = 1'b0;
    logic        rst;
    logic        pc_src;
    logic [31:0] alu_result;
    logic        inst_done;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic        imem_rsp_ready;
    logic [31:0] imem_rsp_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] snpc;
    logic        halted;
    logic        fault;
    logic [31:0] instret;

    ifu_fetch #(.RESET_PC(RESET_PC), .EBREAK_INST(EBREAK)) dut (
        .clk(clk), .rst(rst), .pc_src(pc_src), .alu_result(alu_result),
        .inst_done(inst_done), .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_ready(imem_rsp_ready),
        .imem_rsp_data(imem_rsp_data), .inst(inst), .inst_valid(inst_valid),
        .pc(pc), .snpc(snpc), .halted(halted), .fault(fault), .instret(instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } hold_t;

    logic [31:0] addr_q[$];
    hold_t       hold_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: on each request handshake or each new instruction in HOLD,
    // compare against the next expected queue entry.
    logic inst_valid_prev = 1'b0;
    always @(negedge clk) begin
        if (imem_req_valid && imem_req_ready) begin
            if (addr_q.size() == 0) begin
                check("unexpected_request", imem_addr, 32'hFFFF_FFFF);
            end else begin
                check("req_addr", imem_addr, addr_q.pop_front());
            end
        end
        if (inst_valid && !inst_valid_prev) begin
            if (hold_q.size() == 0) begin
                check("unexpected_hold", inst, 32'hFFFF_FFFF);
            end else begin
                hold_t h;
                h = hold_q.pop_front();
                check("hold_pc", pc, h.pc);
                check("hold_inst", inst, h.inst);
            end
        end
        inst_valid_prev <= inst_valid;
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    // One zero-wait fetch: request handshake, response on the next cycle,
    // then the instruction must be held one cycle after the response.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        int n;
        n = 0;
        while (!imem_req_valid && n < 50) begin
            step();
            n++;
        end
        if (n == 50) check("req_timeout", 32'h0, 32'h1);
        addr_q.push_back(a);
        hold_q.push_back('{pc: a, inst: d});
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("rsp_ready_in_wait", {31'h0, imem_rsp_ready}, 32'h1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = d;
        step();
        imem_rsp_valid = 1'b0;
        check("inst_valid_after_rsp", {31'h0, inst_valid}, 32'h1);
    endtask

    task automatic retire(input logic sel, input logic [31:0] target);
        pc_src     = sel;
        alu_result = target;
        inst_done  = 1'b1;
        step();
        inst_done  = 1'b0;
        pc_src     = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        rst = 1'b1; pc_src = 1'b0; alu_result = '0; inst_done = 1'b0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Values held during reset.
        step();
        step();
        @(negedge clk);
        check("rst_req_valid", {31'h0, imem_req_valid}, 32'h0);
        check("rst_rsp_ready", {31'h0, imem_rsp_ready}, 32'h0);
        check("rst_pc", pc, RESET_PC);
        check("rst_inst", inst, 32'h0);
        check("rst_inst_valid", {31'h0, inst_valid}, 32'h0);
        check("rst_halted", {31'h0, halted}, 32'h0);
        check("rst_fault", {31'h0, fault}, 32'h0);
        check("rst_instret", instret, 32'h0);

        // A request must appear in the first cycle after reset is released.
        @(posedge clk); #2;
        rst = 1'b0;
        @(negedge clk);
        check("first_req_valid", {31'h0, imem_req_valid}, 32'h1);
        check("first_req_addr", imem_addr, RESET_PC);
        step();

        // Sequential fetch.
        fetch(32'h8000_0000, 32'h0000_0093);
        retire(1'b0, 32'h0);
        check("instret_1", instret, 32'd1);
        check("seq_next_addr", imem_addr, 32'h8000_0004);

        // HOLD must keep inst and pc while inst_done=0, and ignore a stray response.
        fetch(32'h8000_0004, 32'h0000_0013);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        step(); step(); step();
        imem_rsp_valid = 1'b0;
        check("hold_inst_stable", inst, 32'h0000_0013);
        check("hold_pc_stable", pc, 32'h8000_0004);
        check("hold_valid_stable", {31'h0, inst_valid}, 32'h1);

        // Jump with bit 0 set: bit 0 cleared, no fault.
        retire(1'b1, 32'h8000_0101);
        check("jump_addr", imem_addr, 32'h8000_0100);
        check("jump_no_fault", {31'h0, fault}, 32'h0);
        check("jump_not_halted", {31'h0, halted}, 32'h0);
        check("instret_2", instret, 32'd2);

        // Jump to the top word; snpc then wraps to zero without a fault.
        fetch(32'h8000_0100, 32'h0000_0033);
        retire(1'b1, 32'hFFFF_FFFD);
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("snpc_wrap", snpc, 32'h0000_0000);
        fetch(32'hFFFF_FFFC, 32'h0000_0013);
        retire(1'b0, 32'h0);
        check("wrap_pc", pc, 32'h0000_0000);
        check("wrap_no_fault", {31'h0, fault}, 32'h0);

        // A misaligned target causes a fault.
        fetch(32'h0000_0000, 32'h0000_0013);
        retire(1'b1, 32'h8000_0102);
        check("fault_halted", {31'h0, halted}, 32'h1);
        check("fault_flag", {31'h0, fault}, 32'h1);
        check("fault_pc", pc, 32'h8000_0102);
        check("instret_5", instret, 32'd5);
        imem_req_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (imem_req_valid) seen++;
        end
        imem_req_ready = 1'b0;
        check("fault_no_requests", seen, 0);

        // Ebreak halts at its own pc without a fault.
        do_reset();
        fetch(RESET_PC, EBREAK);
        retire(1'b1, 32'h1234_5678);
        check("ebreak_halted", {31'h0, halted}, 32'h1);
        check("ebreak_fault", {31'h0, fault}, 32'h0);
        check("ebreak_pc", pc, RESET_PC);
        check("ebreak_instret", instret, 32'd1);
        imem_req_ready = 1'b1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req_valid) seen++;
        end
        imem_req_ready = 1'b0;
        check("ebreak_no_requests", seen, 0);

        // Stalled request, then reset in WAIT; a late response must be ignored.
        do_reset();
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!imem_req_valid || imem_addr !== RESET_PC) seen++;
        end
        check("stall_addr_stable", seen, 0);
        addr_q.push_back(RESET_PC);
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        check("in_wait", {31'h0, imem_rsp_ready}, 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_rsp_ready", {31'h0, imem_rsp_ready}, 32'h0);
        check("midrst_pc", pc, RESET_PC);
        step();
        rst = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0BAD_0BAD;
        step(); step();
        imem_rsp_valid = 1'b0;
        check("stray_rsp_no_valid", {31'h0, inst_valid}, 32'h0);
        check("stray_rsp_inst", inst, 32'h0);
        check("stray_rsp_still_req", {31'h0, imem_req_valid}, 32'h1);
        fetch(RESET_PC, 32'h0000_0093);
        check("after_rst_inst", inst, 32'h0000_0093);

        step();
        check("addr_q_empty", addr_q.size(), 0);
        check("hold_q_empty", hold_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
